// File: rtl/m2_idct_scheduler.sv
// m2_idct_scheduler: block sequencer for the Milestone 2 IDCT datapath.
// Overlaps fetch with compute-S and compute-T with write, and tracks per-block SRAM addresses.
module m2_idct_cursor #(
    parameter int COLS_Y    = 40,
    parameter int COLS_UV   = 20,
    parameter int ROWS      = 30,
    parameter int BASE_Y    = 0,
    parameter int BASE_U    = 0,
    parameter int BASE_V    = 0,
    parameter int STRIDE_Y  = 0,
    parameter int STRIDE_UV = 0,
    parameter int STEP      = 8
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        clear,
    input  logic        adv,
    output logic [17:0] addr,
    output logic [8:0]  stride
);
    logic [1:0]  seg, seg_n;
    logic [11:0] row, col;
    logic [17:0] row_addr, seg_base, row_next;
    logic [8:0]  stride_n;
    logic        last_col, last_row;

    always_comb begin
        last_col = col == 12'((seg == 2'd0 ? COLS_Y : COLS_UV) - 1);
        last_row = row == 12'(ROWS - 1);
        seg_n    = seg == 2'd2 ? 2'd0 : seg + 2'd1;
        seg_base = seg_n == 2'd0 ? 18'(BASE_Y) : seg_n == 2'd1 ? 18'(BASE_U) : 18'(BASE_V);
        stride_n = seg_n == 2'd0 ? 9'(STRIDE_Y) : 9'(STRIDE_UV);
        // one block-row down is 8 pixel rows of the current stride
        row_next = last_row ? seg_base : row_addr + {6'd0, stride, 3'd0};
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            {seg, row, col, row_addr, addr, stride} <= '0;
        end else if (clear) begin
            {seg, row, col} <= '0;
            row_addr <= 18'(BASE_Y);
            addr     <= 18'(BASE_Y);
            stride   <= 9'(STRIDE_Y);
        end else if (adv) begin
            if (!last_col) begin
                col  <= col + 12'd1;
                addr <= addr + 18'(STEP);
            end else begin
                col      <= '0;
                row      <= last_row ? 12'd0 : row + 12'd1;
                row_addr <= row_next;
                addr     <= row_next;
                if (last_row) begin
                    seg    <= seg_n;
                    stride <= stride_n;
                end
            end
        end
    end
endmodule

module m2_idct_scheduler #(
    parameter int Y_BLK_COLS    = 40,
    parameter int UV_BLK_COLS   = 20,
    parameter int BLK_ROWS      = 30,
    parameter int PRE_IDCT_BASE = 76800,
    parameter int Y_WR_BASE     = 0,
    parameter int U_WR_BASE     = 38400,
    parameter int V_WR_BASE     = 57600
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Enable,
    output logic        busy,
    output logic        done,
    output logic        fs_start,
    output logic        ct_start,
    output logic        cs_start,
    output logic        ws_start,
    input  logic        fs_done,
    input  logic        ct_done,
    input  logic        cs_done,
    input  logic        ws_done,
    output logic [17:0] fs_base_addr,
    output logic [8:0]  fs_row_stride,
    output logic [17:0] ws_base_addr,
    output logic [8:0]  ws_row_stride,
    output logic        sram_sel
);
    localparam int N           = BLK_ROWS * (Y_BLK_COLS + 2 * UV_BLK_COLS);
    localparam int FS_STR_Y    = Y_BLK_COLS * 8;
    localparam int FS_STR_UV   = UV_BLK_COLS * 8;
    localparam int FS_U_BASE   = PRE_IDCT_BASE + BLK_ROWS * 8 * FS_STR_Y;
    localparam int FS_V_BASE   = FS_U_BASE + BLK_ROWS * 8 * FS_STR_UV;

    typedef enum logic [2:0] {IDLE, LI_FS, LI_CT, CS_FS, CT_WS, LO_CS, LO_WS, DONE} state_t;

    state_t      state, state_n;
    logic        entry, complete, start_run;
    logic [3:0]  expect_v, got, sticky;
    logic [11:0] fetched;

    // engine bit order: 0 fetch S', 1 compute T, 2 compute S, 3 write S
    always_comb begin
        expect_v  = {state == CT_WS || state == LO_WS, state == CS_FS || state == LO_CS,
                     state == LI_CT || state == CT_WS, state == LI_FS || state == CS_FS};
        got       = sticky | ({ws_done, cs_done, ct_done, fs_done} & expect_v);
        complete  = |expect_v && got == expect_v;
        start_run = state == IDLE && Enable;
        state_n   = state;
        case (state)
            IDLE:    if (Enable) state_n = LI_FS;
            LI_FS:   if (complete) state_n = LI_CT;
            LI_CT:   if (complete) state_n = N > 1 ? CS_FS : LO_CS;
            CS_FS:   if (complete) state_n = CT_WS;
            CT_WS:   if (complete) state_n = fetched == 12'(N) ? LO_CS : CS_FS;
            LO_CS:   if (complete) state_n = LO_WS;
            LO_WS:   if (complete) state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state   <= IDLE;
            entry   <= 1'b0;
            sticky  <= '0;
            fetched <= '0;
        end else begin
            state   <= state_n;
            entry   <= state_n != state;
            sticky  <= complete ? 4'd0 : got;
            fetched <= start_run ? 12'd0 : fetched + 12'(complete && expect_v[0]);
        end
    end

    assign fs_start = entry & expect_v[0];
    assign ct_start = entry & expect_v[1];
    assign cs_start = entry & expect_v[2];
    assign ws_start = entry & expect_v[3];
    assign sram_sel = expect_v[3];
    assign done     = state == DONE;
    assign busy     = state != IDLE && state != DONE;

    m2_idct_cursor #(
        .COLS_Y(Y_BLK_COLS), .COLS_UV(UV_BLK_COLS), .ROWS(BLK_ROWS),
        .BASE_Y(PRE_IDCT_BASE), .BASE_U(FS_U_BASE), .BASE_V(FS_V_BASE),
        .STRIDE_Y(FS_STR_Y), .STRIDE_UV(FS_STR_UV), .STEP(8)
    ) u_fetch (
        .Clock(Clock), .Resetn(Resetn), .clear(start_run), .adv(complete & expect_v[0]),
        .addr(fs_base_addr), .stride(fs_row_stride)
    );

    m2_idct_cursor #(
        .COLS_Y(Y_BLK_COLS), .COLS_UV(UV_BLK_COLS), .ROWS(BLK_ROWS),
        .BASE_Y(Y_WR_BASE), .BASE_U(U_WR_BASE), .BASE_V(V_WR_BASE),
        .STRIDE_Y(Y_BLK_COLS * 4), .STRIDE_UV(UV_BLK_COLS * 4), .STEP(4)
    ) u_write (
        .Clock(Clock), .Resetn(Resetn), .clear(start_run), .adv(complete & expect_v[3]),
        .addr(ws_base_addr), .stride(ws_row_stride)
    );
endmodule

// File: tb/tb_m2_idct_scheduler.sv
// tb_m2_idct_scheduler: directed bench over a small config, a single-block config and the default full frame.
module tb_m2_idct_scheduler;
    logic Clock = 1'b0;
    logic Resetn = 1'b0;
    always #5 Clock = ~Clock;

    logic [2:0]       en = '0;
    logic [2:0][3:0]  st, dn;
    logic [2:0]       busy, done_o, sram;
    logic [2:0][17:0] fa, wa;
    logic [2:0][8:0]  fstr, wstr;
    int               dly[3][4];
    int               cnt[3][4];
    logic             stray = 1'b0;
    int               checks = 0, errors = 0;

    localparam int FA_EXP[8]  = '{76800, 76808, 76928, 76936, 77056, 77120, 77184, 77248};
    localparam int FS_STR[8]  = '{16, 16, 16, 16, 8, 8, 8, 8};
    localparam int WA_EXP[8]  = '{0, 4, 64, 68, 38400, 38432, 57600, 57632};
    localparam int WS_STR[8]  = '{8, 8, 8, 8, 4, 4, 4, 4};
    localparam int TCS[3]     = '{3, 9, 6};
    localparam int TFS[3]     = '{9, 3, 6};
    localparam int TGAP[3]    = '{10, 10, 7};

    m2_idct_scheduler #(.Y_BLK_COLS(2), .UV_BLK_COLS(1), .BLK_ROWS(2)) dut_a (
        .Clock(Clock), .Resetn(Resetn), .Enable(en[0]), .busy(busy[0]), .done(done_o[0]),
        .fs_start(st[0][0]), .ct_start(st[0][1]), .cs_start(st[0][2]), .ws_start(st[0][3]),
        .fs_done(dn[0][0]), .ct_done(dn[0][1]), .cs_done(dn[0][2]), .ws_done(dn[0][3]),
        .fs_base_addr(fa[0]), .fs_row_stride(fstr[0]), .ws_base_addr(wa[0]),
        .ws_row_stride(wstr[0]), .sram_sel(sram[0]));

    m2_idct_scheduler #(.Y_BLK_COLS(1), .UV_BLK_COLS(0), .BLK_ROWS(1)) dut_b (
        .Clock(Clock), .Resetn(Resetn), .Enable(en[1]), .busy(busy[1]), .done(done_o[1]),
        .fs_start(st[1][0]), .ct_start(st[1][1]), .cs_start(st[1][2]), .ws_start(st[1][3]),
        .fs_done(dn[1][0]), .ct_done(dn[1][1]), .cs_done(dn[1][2]), .ws_done(dn[1][3]),
        .fs_base_addr(fa[1]), .fs_row_stride(fstr[1]), .ws_base_addr(wa[1]),
        .ws_row_stride(wstr[1]), .sram_sel(sram[1]));

    m2_idct_scheduler dut_c (
        .Clock(Clock), .Resetn(Resetn), .Enable(en[2]), .busy(busy[2]), .done(done_o[2]),
        .fs_start(st[2][0]), .ct_start(st[2][1]), .cs_start(st[2][2]), .ws_start(st[2][3]),
        .fs_done(dn[2][0]), .ct_done(dn[2][1]), .cs_done(dn[2][2]), .ws_done(dn[2][3]),
        .fs_base_addr(fa[2]), .fs_row_stride(fstr[2]), .ws_base_addr(wa[2]),
        .ws_row_stride(wstr[2]), .sram_sel(sram[2]));

    // engine models: each answers done dly cycles after its start pulse
    always @(posedge Clock or negedge Resetn)
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 4; i++)
                cnt[k][i] <= !Resetn ? 0 : st[k][i] ? dly[k][i] : cnt[k][i] > 0 ? cnt[k][i] - 1 : 0;

    always_comb begin
        dn = '0;
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 4; i++)
                dn[k][i] = cnt[k][i] == 1;
        dn[0][3] = dn[0][3] | stray;
    end

    logic [17:0] fq[$], wq[$];
    logic [8:0]  fsq[$], wsq[$];
    int          pc[4] = '{0, 0, 0, 0};
    int          done_cnt = 0, overlap = 0, sram_bad = 0;
    logic        fs_act = 1'b0, ws_act = 1'b0;
    int          bseq[$];
    logic [17:0] b_fa = '0, b_wa = '0;
    int          c_ws = 0, c_fs = 0, c_done = 0;
    logic [17:0] c_last_wa = '0, c_last_fa = '0;
    logic [8:0]  c_last_wstr = '0;

    always @(negedge Clock) begin
        if (!Resetn) begin
            fs_act = 1'b0;
            ws_act = 1'b0;
        end
        if (st[0][0]) begin fq.push_back(fa[0]); fsq.push_back(fstr[0]); fs_act = 1'b1; end
        if (st[0][3]) begin wq.push_back(wa[0]); wsq.push_back(wstr[0]); ws_act = 1'b1; end
        for (int i = 0; i < 4; i++) pc[i] += int'(st[0][i]);
        done_cnt += int'(done_o[0]);
        if (fs_act && ws_act) overlap++;
        if ((fs_act && sram[0]) || (ws_act && !sram[0])) sram_bad++;
        if (dn[0][0]) fs_act = 1'b0;
        if (dn[0][3]) ws_act = 1'b0;
        for (int i = 0; i < 4; i++) if (st[1][i]) bseq.push_back(i);
        if (done_o[1]) bseq.push_back(4);
        if (st[1][0]) b_fa = fa[1];
        if (st[1][3]) b_wa = wa[1];
        if (st[2][0]) begin c_fs++; c_last_fa = fa[2]; end
        if (st[2][3]) begin c_ws++; c_last_wa = wa[2]; c_last_wstr = wstr[2]; end
        c_done += int'(done_o[2]);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic ev(input int k, input int s);
        return s < 4 ? st[k][s] : done_o[k];
    endfunction

    task automatic wait_ev(input int k, input int s, input int bound, input string tag, output int n);
        n = 0;
        do begin
            @(negedge Clock);
            n++;
        end while (!ev(k, s) && n < bound);
        if (!ev(k, s)) begin
            errors++;
            $error("FAIL %s: timeout after %0d cycles", tag, n);
        end
    endtask

    task automatic pulse_en(input int k);
        @(negedge Clock);
        en[k] = 1'b1;
        @(negedge Clock);
        en[k] = 1'b0;
    endtask

    initial begin
        int n;
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 4; i++)
                dly[k][i] = k == 2 ? 2 : 5;
        #22;
        check("reset_outputs_a", 64'({st[0], busy[0], done_o[0], fa[0], wa[0], fstr[0], wstr[0], sram[0]}), 64'd0);
        check("reset_outputs_c", 64'({st[2], busy[2], done_o[2], fa[2], wa[2], fstr[2], wstr[2], sram[2]}), 64'd0);
        #20 Resetn = 1'b1;

        // small config, with a busy Enable and a stray ws_done during CS_FS
        pulse_en(0);
        check("busy_after_enable", 64'(busy[0]), 64'd1);
        wait_ev(0, 2, 200, "first_cs_start", n);
        stray = 1'b1;
        en[0] = 1'b1;
        @(negedge Clock);
        stray = 1'b0;
        en[0] = 1'b0;
        wait_ev(0, 4, 2000, "run1_done", n);
        check("done_busy_low", 64'(busy[0]), 64'd0);
        repeat (5) @(negedge Clock);
        check("fs_count", 64'(fq.size()), 64'd8);
        check("ws_count", 64'(wq.size()), 64'd8);
        for (int j = 0; j < 8; j++) begin
            check($sformatf("fs_addr[%0d]", j), 64'(fq.size() > j ? fq[j] : '1), 64'(FA_EXP[j]));
            check($sformatf("fs_stride[%0d]", j), 64'(fsq.size() > j ? fsq[j] : '1), 64'(FS_STR[j]));
            check($sformatf("ws_addr[%0d]", j), 64'(wq.size() > j ? wq[j] : '1), 64'(WA_EXP[j]));
            check($sformatf("ws_stride[%0d]", j), 64'(wsq.size() > j ? wsq[j] : '1), 64'(WS_STR[j]));
        end
        for (int i = 0; i < 4; i++) check($sformatf("start_pulses[%0d]", i), 64'(pc[i]), 64'd8);
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("fs_ws_overlap", 64'(overlap), 64'd0);
        check("sram_sel_owner", 64'(sram_bad), 64'd0);
        check("idle_busy", 64'(busy[0]), 64'd0);

        // CS_FS completion waits for the later of cs_done/fs_done
        for (int r = 0; r < 3; r++) begin
            dly[0][2] = TCS[r];
            dly[0][0] = TFS[r];
            pulse_en(0);
            wait_ev(0, 2, 200, "timing_cs_start", n);
            check("cs_fs_together", 64'(st[0][0]), 64'd1);
            wait_ev(0, 1, 50, "timing_ct_start", n);
            check($sformatf("cs_fs_gap[%0d]", r), 64'(n), 64'(TGAP[r]));
            wait_ev(0, 4, 3000, "timing_done", n);
        end
        dly[0][0] = 5;
        dly[0][2] = 5;
        check("overlap_after_timing", 64'(overlap), 64'd0);

        // asynchronous reset in the middle of CT_WS
        pulse_en(0);
        wait_ev(0, 3, 200, "ct_ws_entry", n);
        @(negedge Clock);
        #2 Resetn = 1'b0;
        #1;
        check("async_reset_outputs", 64'({st[0], busy[0], done_o[0], fa[0], wa[0], fstr[0], wstr[0], sram[0]}), 64'd0);
        @(negedge Clock);
        Resetn = 1'b1;
        pulse_en(0);
        check("restart_fs_start", 64'(st[0][0]), 64'd1);
        check("restart_fs_addr", 64'(fa[0]), 64'd76800);
        check("restart_fs_stride", 64'(fstr[0]), 64'd16);
        wait_ev(0, 4, 2000, "restart_done", n);

        // single-block configuration
        pulse_en(1);
        wait_ev(1, 4, 200, "n1_done", n);
        @(negedge Clock);
        check("n1_seq_len", 64'(bseq.size()), 64'd5);
        for (int j = 0; j < 5; j++)
            check($sformatf("n1_seq[%0d]", j), 64'(bseq.size() > j ? bseq[j] : -1), 64'(j));
        check("n1_fs_addr", 64'(b_fa), 64'd76800);
        check("n1_ws_addr", 64'(b_wa), 64'd0);

        // default parameters, full frame
        pulse_en(2);
        wait_ev(2, 4, 60000, "full_done", n);
        @(negedge Clock);
        check("full_ws_pulses", 64'(c_ws), 64'd2400);
        check("full_fs_pulses", 64'(c_fs), 64'd2400);
        check("full_last_ws_addr", 64'(c_last_wa), 64'd76236);
        check("full_last_fs_addr", 64'(c_last_fa), 64'd229272);
        check("full_last_ws_stride", 64'(c_last_wstr), 64'd80);
        check("full_done_pulses", 64'(c_done), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
